// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between NUM_REQ requesters, one transaction in flight.
// Reads return data to the owner one cycle after mem_read_valid, or abort with rsp_err on timeout.
module mem_bus_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_write_data,
  output logic                      mem_dispatch_read,
  output logic                      mem_dispatch_write,
  input  logic [DATA_W-1:0]         mem_read_data,
  input  logic                      mem_read_valid,
  output logic                      busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE, DISPATCH, WAIT_RD, RESP} state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   owner_q;
  logic               we_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [NUM_REQ-1:0] req_ready_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic               rsp_err_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [DATA_W-1:0]  mem_wdata_q;
  logic               mem_rd_q;
  logic               mem_wr_q;
  logic               busy_q;

  logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
  end

  logic             grant_vld;
  logic [IDX_W-1:0] owner_d;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] rr_ptr_d;

  // Scan downward so the lowest offset from rr_ptr is the last (winning) assignment.
  always_comb begin
    grant_vld = 1'b0;
    owner_d   = '0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        grant_vld = 1'b1;
        owner_d   = cand;
      end
    end
    rr_ptr_d = (owner_d == LAST_IDX) ? '0 : owner_d + 1'b1;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            owner_q     <= owner_d;
            we_q        <= req_we[owner_d];
            rr_ptr_q    <= rr_ptr_d;
            req_ready_q <= ONE_HOT0 << owner_d;
            mem_addr_q  <= addr_arr[owner_d];
            mem_wdata_q <= wdata_arr[owner_d];
            mem_rd_q    <= ~req_we[owner_d];
            mem_wr_q    <= req_we[owner_d];
            busy_q      <= 1'b1;
            state_q     <= DISPATCH;
          end
        end
        DISPATCH: begin
          cnt_q <= '0;
          if (we_q) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            state_q <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          // A response arriving on the expiry cycle still counts as good data.
          if (mem_read_valid) begin
            rsp_data_q  <= mem_read_data;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= ONE_HOT0 << owner_q;
            state_q     <= RESP;
          end else if (cnt_q == CNT_LAST) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= ONE_HOT0 << owner_q;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready          = req_ready_q;
  assign rsp_valid          = rsp_valid_q;
  assign rsp_data           = rsp_data_q;
  assign rsp_err            = rsp_err_q;
  assign mem_addr           = mem_addr_q;
  assign mem_write_data     = mem_wdata_q;
  assign mem_dispatch_read  = mem_rd_q;
  assign mem_dispatch_write = mem_wr_q;
  assign busy               = busy_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus randomized traffic against a
// transaction-timeline reference model.
module tb_mem_bus_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 8;
  localparam int TO      = 8;
  localparam int NEVER   = 1 << 30;

  logic                      clk_in = 1'b0;
  logic                      rst_in;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_we;
  logic [ADDR_W-1:0]         a_arr [NUM_REQ];
  logic [DATA_W-1:0]         w_arr [NUM_REQ];
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_err;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_write_data;
  logic                      mem_dispatch_read;
  logic                      mem_dispatch_write;
  logic [DATA_W-1:0]         mem_read_data;
  logic                      mem_read_valid;
  logic                      busy;

  int n_chk  = 0;
  int n_pass = 0;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_flat
    assign req_addr[g*ADDR_W +: ADDR_W]  = a_arr[g];
    assign req_wdata[g*DATA_W +: DATA_W] = w_arr[g];
  end

  always #5 clk_in = ~clk_in;

  mem_bus_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_dispatch_read(mem_dispatch_read), .mem_dispatch_write(mem_dispatch_write),
    .mem_read_data(mem_read_data), .mem_read_valid(mem_read_valid), .busy(busy)
  );

  task automatic apply_reset();
    rst_in = 1'b1;
    req_valid = '0; req_we = '0;
    mem_read_valid = 1'b0; mem_read_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin a_arr[i] = '0; w_arr[i] = '0; end
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    req_valid = '0; req_we = '0;
    mem_read_valid = 1'b0; mem_read_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin a_arr[i] = '0; w_arr[i] = '0; end
    repeat (2) @(negedge clk_in);
    n_chk++;
    if ({req_ready, rsp_valid, rsp_data, rsp_err, mem_addr, mem_write_data,
         mem_dispatch_read, mem_dispatch_write, busy} !== '0)
      $display("FAIL reset_outputs: got ready=%b rsp=%b data=%h err=%b addr=%h wd=%h rd=%b wr=%b busy=%b, want all 0",
               req_ready, rsp_valid, rsp_data, rsp_err, mem_addr, mem_write_data,
               mem_dispatch_read, mem_dispatch_write, busy);
    else n_pass++;
    rst_in = 1'b0;
    @(negedge clk_in);
    n_chk++;
    if ({busy, req_ready} !== '0) $display("FAIL reset_release_idle: busy=%b ready=%b want 0", busy, req_ready);
    else n_pass++;
  endtask

  task automatic test_write();
    req_valid = 2'b01; req_we = 2'b01; a_arr[0] = 16'h1234; w_arr[0] = 8'hA5;
    @(negedge clk_in);
    n_chk++; if (req_ready !== 2'b01) $display("FAIL wr_ready: got %b want 01", req_ready); else n_pass++;
    n_chk++; if ({mem_dispatch_write, mem_dispatch_read} !== 2'b10)
      $display("FAIL wr_strobes: got wr=%b rd=%b want wr=1 rd=0", mem_dispatch_write, mem_dispatch_read); else n_pass++;
    n_chk++; if (mem_addr !== 16'h1234) $display("FAIL wr_addr: got %h want 1234", mem_addr); else n_pass++;
    n_chk++; if (mem_write_data !== 8'hA5) $display("FAIL wr_data: got %h want a5", mem_write_data); else n_pass++;
    n_chk++; if (busy !== 1'b1) $display("FAIL wr_busy: got %b want 1", busy); else n_pass++;
    req_valid = '0;
    @(negedge clk_in);
    n_chk++; if ({busy, mem_dispatch_write, req_ready} !== '0)
      $display("FAIL wr_done: busy=%b wr=%b ready=%b want 0", busy, mem_dispatch_write, req_ready); else n_pass++;
    n_chk++; if (mem_addr !== 16'h1234) $display("FAIL wr_addr_hold: got %h want 1234", mem_addr); else n_pass++;
  endtask

  task automatic test_read();
    int nrd = 0;
    req_valid = 2'b10; req_we = 2'b00; a_arr[1] = 16'h0040;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk_in);
      if (mem_dispatch_read) nrd++;
      if (k == 0) begin
        n_chk++; if (req_ready !== 2'b10) $display("FAIL rd_ready: got %b want 10", req_ready); else n_pass++;
        n_chk++; if (mem_addr !== 16'h0040) $display("FAIL rd_addr: got %h want 0040", mem_addr); else n_pass++;
        req_valid = '0;
      end
      if (k == 4) begin
        n_chk++; if (rsp_valid !== 2'b10 || rsp_data !== 8'h3C || rsp_err !== 1'b0)
          $display("FAIL rd_rsp: got v=%b d=%h e=%b want v=10 d=3c e=0", rsp_valid, rsp_data, rsp_err); else n_pass++;
      end else begin
        n_chk++; if (rsp_valid !== 2'b00) $display("FAIL rd_no_rsp k=%0d: got %b want 00", k, rsp_valid); else n_pass++;
      end
      if (k == 5) begin
        n_chk++; if (busy !== 1'b0) $display("FAIL rd_idle: busy=%b want 0", busy); else n_pass++;
      end
      mem_read_valid = (k == 3);
      mem_read_data  = (k == 3) ? 8'h3C : 8'hFF;
    end
    mem_read_valid = 1'b0;
    n_chk++; if (nrd != 1) $display("FAIL rd_single_dispatch: got %0d want 1", nrd); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [NUM_REQ-1:0] exp_rdy;
    apply_reset();
    req_valid = 2'b11; req_we = 2'b11;
    a_arr[0] = 16'h1000; a_arr[1] = 16'h2000; w_arr[0] = 8'h10; w_arr[1] = 8'h20;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_in);
      exp_rdy = (k % 2 == 0) ? 2'b00 : ((k % 4 == 1) ? 2'b01 : 2'b10);
      n_chk++; if (req_ready !== exp_rdy) $display("FAIL b2b_ready k=%0d: got %b want %b", k, req_ready, exp_rdy); else n_pass++;
      n_chk++; if (mem_dispatch_write !== 1'(k % 2))
        $display("FAIL b2b_strobe k=%0d: got %b want %0d", k, mem_dispatch_write, k % 2); else n_pass++;
      if (k % 2 == 1) begin
        n_chk++; if (mem_addr !== ((k % 4 == 1) ? 16'h1000 : 16'h2000))
          $display("FAIL b2b_addr k=%0d: got %h", k, mem_addr); else n_pass++;
      end
      if (k == 8) req_valid = '0;
    end
  endtask

  task automatic test_early_valid();
    req_valid = 2'b01; req_we = 2'b00; a_arr[0] = 16'h0077;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk_in);
      if (k == 0) begin
        n_chk++; if (req_ready !== 2'b01 || mem_dispatch_read !== 1'b1)
          $display("FAIL early_grant: ready=%b rd=%b want 01/1", req_ready, mem_dispatch_read); else n_pass++;
        req_valid = '0;
      end
      if (k == 3) begin
        n_chk++; if (rsp_valid !== 2'b01 || rsp_data !== 8'h77 || rsp_err !== 1'b0)
          $display("FAIL early_rsp: got v=%b d=%h e=%b want v=01 d=77 e=0", rsp_valid, rsp_data, rsp_err); else n_pass++;
      end else begin
        n_chk++; if (rsp_valid !== 2'b00) $display("FAIL early_no_rsp k=%0d: got %b want 00", k, rsp_valid); else n_pass++;
      end
      mem_read_valid = (k == 0 || k == 2);
      mem_read_data  = (k == 0) ? 8'hEE : 8'h77;
    end
    mem_read_valid = 1'b0;
  endtask

  task automatic test_timeout();
    req_valid = 2'b01; req_we = 2'b00; a_arr[0] = 16'h0ABC; mem_read_valid = 1'b0;
    for (int k = 0; k <= 11; k++) begin
      @(negedge clk_in);
      if (k == 0) begin
        n_chk++; if (req_ready !== 2'b01 || mem_dispatch_read !== 1'b1)
          $display("FAIL to_grant: ready=%b rd=%b want 01/1", req_ready, mem_dispatch_read); else n_pass++;
        req_valid = '0;
      end
      if (k == 9) begin
        n_chk++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rsp_data !== 8'h00)
          $display("FAIL to_rsp: got v=%b d=%h e=%b want v=01 d=00 e=1", rsp_valid, rsp_data, rsp_err); else n_pass++;
        req_valid = 2'b10; req_we = 2'b10; a_arr[1] = 16'h5555; w_arr[1] = 8'h11;
      end else if (k <= 10) begin
        n_chk++; if (rsp_valid !== 2'b00) $display("FAIL to_no_rsp k=%0d: got %b want 00", k, rsp_valid); else n_pass++;
      end
      if (k == 10) begin
        n_chk++; if (req_ready !== 2'b00 || busy !== 1'b0)
          $display("FAIL to_idle: ready=%b busy=%b want 00/0", req_ready, busy); else n_pass++;
      end
      if (k == 11) begin
        n_chk++; if (req_ready !== 2'b10 || mem_dispatch_write !== 1'b1 || mem_addr !== 16'h5555 || mem_write_data !== 8'h11)
          $display("FAIL to_next: ready=%b wr=%b addr=%h wd=%h want 10/1/5555/11",
                   req_ready, mem_dispatch_write, mem_addr, mem_write_data); else n_pass++;
        req_valid = '0;
      end
    end
    @(negedge clk_in);
  endtask

  task automatic test_async_reset();
    req_valid = 2'b01; req_we = 2'b00; a_arr[0] = 16'hBEEF;
    @(negedge clk_in);
    req_valid = '0;
    @(negedge clk_in);
    n_chk++; if (busy !== 1'b1) $display("FAIL ar_pre_busy: got %b want 1", busy); else n_pass++;
    #2 rst_in = 1'b1;
    #1;
    n_chk++;
    if ({req_ready, rsp_valid, rsp_data, rsp_err, mem_addr, mem_write_data,
         mem_dispatch_read, mem_dispatch_write, busy} !== '0)
      $display("FAIL ar_outputs: ready=%b rsp=%b data=%h err=%b addr=%h wd=%h busy=%b want all 0",
               req_ready, rsp_valid, rsp_data, rsp_err, mem_addr, mem_write_data, busy);
    else n_pass++;
    mem_read_valid = 1'b1; mem_read_data = 8'h99;
    @(negedge clk_in);
    mem_read_valid = 1'b0; rst_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      n_chk++; if (rsp_valid !== 2'b00 || busy !== 1'b0)
        $display("FAIL ar_quiet k=%0d: rsp=%b busy=%b want 00/0", k, rsp_valid, busy); else n_pass++;
    end
    req_valid = 2'b11; req_we = 2'b11; a_arr[0] = 16'hA000; a_arr[1] = 16'hB000;
    @(negedge clk_in);
    n_chk++; if (req_ready !== 2'b01 || mem_addr !== 16'hA000)
      $display("FAIL ar_tie: ready=%b addr=%h want 01/a000", req_ready, mem_addr); else n_pass++;
    req_valid = '0;
    @(negedge clk_in);
  endtask

  // Reference: arbiter is idle at cycle idle_at and grants from rr; a write frees it two
  // cycles later, a read answers the cycle after the first valid in its TO-cycle wait window.
  task automatic test_random();
    int idle_at, rd_disp, rd_owner, rr, own;
    bit rd_on;
    bit active [NUM_REQ];
    logic [NUM_REQ-1:0] e_ready, e_rsp;
    logic [ADDR_W-1:0]  e_addr;
    logic [DATA_W-1:0]  e_wdata, e_rdata;
    logic e_err, e_rd, e_wr, e_busy;
    apply_reset();
    idle_at = 0; rr = 0; rd_on = 0; rd_disp = 0; rd_owner = 0; own = 0;
    e_ready = '0; e_rsp = '0; e_addr = '0; e_wdata = '0; e_rdata = '0;
    e_err = 0; e_rd = 0; e_wr = 0; e_busy = 0;
    for (int i = 0; i < NUM_REQ; i++) active[i] = 0;
    for (int c = 0; c < 1500; c++) begin
      if (c > 0) @(negedge clk_in);
      n_chk++; if (req_ready !== e_ready) $display("FAIL rnd_ready c=%0d: got %b want %b", c, req_ready, e_ready); else n_pass++;
      n_chk++; if ({mem_dispatch_read, mem_dispatch_write} !== {e_rd, e_wr})
        $display("FAIL rnd_strobe c=%0d: got %b%b want %b%b", c, mem_dispatch_read, mem_dispatch_write, e_rd, e_wr); else n_pass++;
      n_chk++; if (mem_addr !== e_addr || mem_write_data !== e_wdata)
        $display("FAIL rnd_bus c=%0d: got %h/%h want %h/%h", c, mem_addr, mem_write_data, e_addr, e_wdata); else n_pass++;
      n_chk++; if (busy !== e_busy) $display("FAIL rnd_busy c=%0d: got %b want %b", c, busy, e_busy); else n_pass++;
      n_chk++; if (rsp_valid !== e_rsp) $display("FAIL rnd_rsp c=%0d: got %b want %b", c, rsp_valid, e_rsp); else n_pass++;
      if (e_rsp != 0) begin
        n_chk++; if (rsp_data !== e_rdata || rsp_err !== e_err)
          $display("FAIL rnd_rdata c=%0d: got %h/%b want %h/%b", c, rsp_data, rsp_err, e_rdata, e_err); else n_pass++;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i]) active[i] = 0;
        if (!active[i] && $urandom_range(2) == 0) begin
          active[i] = 1;
          req_we[i] = 1'($urandom_range(1));
          a_arr[i]  = ADDR_W'($urandom);
          w_arr[i]  = DATA_W'($urandom);
        end else if (active[i] && $urandom_range(15) == 0) begin
          active[i] = 0;
        end
        req_valid[i] = active[i];
      end
      mem_read_valid = ($urandom_range(3) == 0);
      mem_read_data  = DATA_W'($urandom);
      e_ready = '0; e_rsp = '0; e_rd = 0; e_wr = 0;
      if (c == idle_at) begin
        if (req_valid != 0) begin
          own = -1;
          for (int s = 0; s < NUM_REQ; s++)
            if (own < 0 && active[(rr + s) % NUM_REQ]) own = (rr + s) % NUM_REQ;
          e_ready = NUM_REQ'(1) << own;
          e_addr  = a_arr[own];
          e_wdata = w_arr[own];
          rr = (own + 1) % NUM_REQ;
          if (req_we[own]) begin
            e_wr = 1; idle_at = c + 2;
          end else begin
            e_rd = 1; rd_on = 1; rd_disp = c + 1; rd_owner = own; idle_at = NEVER;
          end
        end else begin
          idle_at = c + 1;
        end
      end else if (rd_on && c > rd_disp) begin
        if (mem_read_valid) begin
          e_rsp = NUM_REQ'(1) << rd_owner; e_rdata = mem_read_data; e_err = 0;
        end else if (c - rd_disp == TO) begin
          e_rsp = NUM_REQ'(1) << rd_owner; e_rdata = '0; e_err = 1;
        end
        if (e_rsp != 0) begin rd_on = 0; idle_at = c + 2; end
      end
      e_busy = (c + 1 != idle_at);
    end
    req_valid = '0; mem_read_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_early_valid();
    test_timeout();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
